sr_flag_arbiter: RTL and testbench

- Round-robin controller sharing a bank of NFLAGS clocked SR flag cells between NREQ requesters.
- Each requester issues a hold, reset or set command to one flag address. The block grants one requester at a time, applies the S/R pair to the addressed cell, and reports completion.
- It also detects and blocks the forbidden S=R=1 condition.
- It sits between software-facing or control requesters and the gated SR storage used elsewhere in the design.

---
 rtl/sr_flag_pkg.sv | 19 +
 rtl/sr_rr_arbiter.sv | 46 ++++
 rtl/sr_flag_arbiter.sv | 119 +++++++++++
 tb/tb_sr_flag_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_flag_pkg.sv
// ============================================================================
// sr_flag_pkg : command and FSM state encodings for sr_flag_arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package sr_flag_pkg;

  localparam logic [1:0] CMD_HOLD = 2'b00;
  localparam logic [1:0] CMD_RST  = 2'b01;
  localparam logic [1:0] CMD_SET  = 2'b10;
  localparam logic [1:0] CMD_BAD  = 2'b11;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_EXEC  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/sr_rr_arbiter.sv
// ============================================================================
// sr_rr_arbiter : combinational round-robin select, first request at/after ptr
// Rev 1.0
// ============================================================================
`default_nettype none

module sr_rr_arbiter
  import sr_flag_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   grant_idx
);

  logic          found;
  logic [PW:0]   sum;
  logic [PW-1:0] cand;

  // One extra bit on the sum lets the wrap work for non-power-of-two NREQ.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    sum       = '0;
    cand      = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum = {1'b0, ptr} + (PW+1)'(i);
      if (sum >= (PW+1)'(NREQ)) begin
        sum = sum - (PW+1)'(NREQ);
      end
      cand = sum[PW-1:0];
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/sr_flag_arbiter.sv
// ============================================================================
// sr_flag_arbiter : round-robin access to a bank of SR flag cells
// Optional macro SR_FLAG_TOGGLE_EN: cmd 11 toggles the flag instead of err.
// Rev 1.0
// ============================================================================
`default_nettype none

module sr_flag_arbiter
  import sr_flag_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int NFLAGS = 8,
  parameter int AW     = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [2*NREQ-1:0]    cmd,
  input  logic [AW*NREQ-1:0]   addr,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic [NFLAGS-1:0]    q,
  output logic [NFLAGS-1:0]    qbar,
  output logic                 err,
  output logic                 busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [0:0]        state, state_nxt;
  logic [PW-1:0]     ptr, win_idx, cur_idx;
  logic [NREQ-1:0]   win_oh, cur_oh;
  logic [1:0]        cur_cmd;
  logic [AW-1:0]     cur_addr;
  logic [NFLAGS-1:0] q_r;
  logic [NREQ-1:0]   done_r;
  logic              err_r;

  sr_rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_arb (
    .req       (req),
    .ptr       (ptr),
    .grant     (win_oh),
    .grant_idx (win_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (|req) state_nxt = ST_EXEC;
      ST_EXEC: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    gnt  = '0;
    if (state == ST_EXEC) begin
      busy = 1'b1;
      gnt  = cur_oh;
    end
  end

  // cmd/addr are snapshotted at grant; later changes on the inputs are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr      <= '0;
      cur_oh   <= '0;
      cur_idx  <= '0;
      cur_cmd  <= CMD_HOLD;
      cur_addr <= '0;
      q_r      <= '0;
      done_r   <= '0;
      err_r    <= 1'b0;
    end else begin
      done_r <= '0;
      err_r  <= 1'b0;
      if (state == ST_IDLE) begin
        if (|req) begin
          cur_oh   <= win_oh;
          cur_idx  <= win_idx;
          cur_cmd  <= cmd[2*win_idx +: 2];
          cur_addr <= addr[AW*win_idx +: AW];
        end
      end else begin
        case (cur_cmd)
          CMD_RST: q_r[cur_addr] <= 1'b0;
          CMD_SET: q_r[cur_addr] <= 1'b1;
          CMD_BAD: begin
`ifdef SR_FLAG_TOGGLE_EN
            q_r[cur_addr] <= ~q_r[cur_addr];
`else
            err_r <= 1'b1;
`endif
          end
          default: ;
        endcase
        done_r <= cur_oh;
        ptr    <= (cur_idx == PW'(NREQ-1)) ? '0 : cur_idx + 1'b1;
      end
    end
  end

  assign q    = q_r;
  assign qbar = ~q_r;
  assign done = done_r;
  assign err  = err_r;

endmodule

`default_nettype wire

// File: tb/tb_sr_flag_arbiter.sv
// ============================================================================
// tb_sr_flag_arbiter : directed scenarios plus random traffic vs a service model
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_sr_flag_arbiter;

  localparam int NREQ   = 4;
  localparam int NFLAGS = 8;
  localparam int AW     = 3;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req;
  logic [2*NREQ-1:0]   cmd;
  logic [AW*NREQ-1:0]  addr;
  logic [NREQ-1:0]     gnt, done;
  logic [NFLAGS-1:0]   q, qbar;
  logic                err, busy;

  int n_vec = 0;
  int n_err = 0;

  sr_flag_arbiter #(.NREQ(NREQ), .NFLAGS(NFLAGS), .AW(AW)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .cmd  (cmd),
    .addr (addr),
    .gnt  (gnt),
    .done (done),
    .q    (q),
    .qbar (qbar),
    .err  (err),
    .busy (busy)
  );

  always #5 clk = ~clk;

  // Service-level reference: one grant, then one apply cycle, fair rotation.
  int              m_ptr;
  logic            m_exec;
  int              m_win;
  logic [1:0]      m_cmd;
  logic [AW-1:0]   m_addr;
  logic [NFLAGS-1:0] m_q;
  logic [NREQ-1:0] m_done;
  logic            m_err;
  int              pick;
  logic [NREQ-1:0] m_gnt;

  function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++)
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  always_comb pick = rr_pick(req, m_ptr);
  always_comb m_gnt = m_exec ? (NREQ'(1) << m_win) : '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ptr <= 0; m_exec <= 1'b0; m_win <= 0; m_cmd <= 2'b00; m_addr <= '0;
      m_q <= '0; m_done <= '0; m_err <= 1'b0;
    end else begin
      m_done <= '0;
      m_err  <= 1'b0;
      if (!m_exec) begin
        if (pick >= 0) begin
          m_exec <= 1'b1;
          m_win  <= pick;
          m_cmd  <= cmd[2*pick +: 2];
          m_addr <= addr[AW*pick +: AW];
        end
      end else begin
        if (m_cmd == 2'b01) m_q[m_addr] <= 1'b0;
        if (m_cmd == 2'b10) m_q[m_addr] <= 1'b1;
`ifdef SR_FLAG_TOGGLE_EN
        if (m_cmd == 2'b11) m_q[m_addr] <= ~m_q[m_addr];
`else
        if (m_cmd == 2'b11) m_err <= 1'b1;
`endif
        m_done <= NREQ'(1) << m_win;
        m_ptr  <= (m_win + 1) % NREQ;
        m_exec <= 1'b0;
      end
    end
  end

  task automatic set_cmd(input int i, input logic [1:0] c, input logic [AW-1:0] a);
    cmd[2*i +: 2]   = c;
    addr[AW*i +: AW] = a;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (q !== 8'h00)    begin n_err++; $display("FAIL reset_q: got %h want 00", q); end
    n_vec++; if (qbar !== 8'hFF) begin n_err++; $display("FAIL reset_qbar: got %h want ff", qbar); end
    n_vec++; if (gnt !== 4'h0)   begin n_err++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    n_vec++; if (done !== 4'h0)  begin n_err++; $display("FAIL reset_done: got %b want 0000", done); end
    n_vec++; if (err !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL reset_err_busy: got %b%b want 00", err, busy); end
  endtask

  task automatic test_single();
    do_reset();
    set_cmd(0, 2'b10, 3'd3);
    req = 4'b0001;
    @(negedge clk);
    n_vec++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL single_gnt: got %b want 0001", gnt); end
    n_vec++; if (busy !== 1'b1 || q !== 8'h00) begin n_err++; $display("FAIL single_exec: busy %b q %h want 1 00", busy, q); end
    @(negedge clk);
    n_vec++; if (q !== 8'h08)     begin n_err++; $display("FAIL single_set_q: got %h want 08", q); end
    n_vec++; if (done !== 4'b0001) begin n_err++; $display("FAIL single_done: got %b want 0001", done); end
    n_vec++; if (gnt !== 4'b0000 || busy !== 1'b0) begin n_err++; $display("FAIL single_clear: gnt %b busy %b want 0000 0", gnt, busy); end
    req = '0;
    @(negedge clk);
    n_vec++; if (done !== 4'b0000 || gnt !== 4'b0000) begin n_err++; $display("FAIL single_idle: done %b gnt %b want 0000 0000", done, gnt); end
    set_cmd(0, 2'b01, 3'd3);
    req = 4'b0001;
    @(negedge clk);
    @(negedge clk);
    n_vec++; if (q !== 8'h00 || qbar !== 8'hFF) begin n_err++; $display("FAIL single_rst_q: q %h qbar %h want 00 ff", q, qbar); end
    req = '0;
    @(negedge clk);
  endtask

  task automatic rr_pass(input int start, input int base, input logic [7:0] expq);
    int cnt [NREQ];
    int exp_i;
    for (int i = 0; i < NREQ; i++) begin
      cnt[i] = 0;
      set_cmd(i, 2'b10, AW'(base + i));
    end
    req = 4'b1111;
    for (int cyc = 0; cyc < 2*NREQ; cyc++) begin
      @(negedge clk);
      exp_i = (start + cyc/2) % NREQ;
      if (cyc % 2 == 0) begin
        n_vec++; if (gnt !== (NREQ'(1) << exp_i)) begin n_err++; $display("FAIL rr_gnt start%0d slot%0d: got %b want req %0d", start, cyc/2, gnt, exp_i); end
      end else begin
        n_vec++; if (done !== (NREQ'(1) << exp_i)) begin n_err++; $display("FAIL rr_done start%0d slot%0d: got %b want req %0d", start, cyc/2, done, exp_i); end
        for (int k = 0; k < NREQ; k++) if (done[k]) cnt[k]++;
        req[exp_i] = 1'b0;
      end
    end
    n_vec++; if (q !== expq) begin n_err++; $display("FAIL rr_q start%0d: got %h want %h", start, q, expq); end
    for (int i = 0; i < NREQ; i++) begin
      n_vec++; if (cnt[i] != 1) begin n_err++; $display("FAIL rr_count start%0d req%0d: got %0d want 1", start, i, cnt[i]); end
    end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    do_reset();
    rr_pass(0, 0, 8'h0F);
    do_reset();
    set_cmd(1, 2'b01, 3'd1);
    req = 4'b0010;
    @(negedge clk);
    @(negedge clk);
    req = '0;
    @(negedge clk);
    rr_pass(2, 4, 8'hF0);
  endtask

  task automatic test_forbidden();
    do_reset();
    set_cmd(2, 2'b10, 3'd5);
    req = 4'b0100;
    @(negedge clk);
    @(negedge clk);
    req = '0;
    @(negedge clk);
    set_cmd(2, 2'b11, 3'd5);
    req = 4'b0100;
    @(negedge clk);
    @(negedge clk);
    req = '0;
`ifdef SR_FLAG_TOGGLE_EN
    n_vec++; if (q !== 8'h00) begin n_err++; $display("FAIL bad_toggle_q: got %h want 00", q); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL bad_toggle_err: got %b want 0", err); end
`else
    n_vec++; if (q !== 8'h20) begin n_err++; $display("FAIL bad_hold_q: got %h want 20", q); end
    n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL bad_err_pulse: got %b want 1", err); end
`endif
    n_vec++; if (done !== 4'b0100) begin n_err++; $display("FAIL bad_done: got %b want 0100", done); end
    @(negedge clk);
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL bad_err_len: got %b want 0", err); end
  endtask

  task automatic test_same_flag();
    do_reset();
    set_cmd(0, 2'b00, 3'd0);
    req = 4'b0001;
    @(negedge clk);
    @(negedge clk);
    req = '0;
    @(negedge clk);
    set_cmd(1, 2'b10, 3'd2);
    set_cmd(2, 2'b01, 3'd2);
    req = 4'b0110;
    @(negedge clk);
    n_vec++; if (gnt !== 4'b0010) begin n_err++; $display("FAIL same_gnt1: got %b want 0010", gnt); end
    @(negedge clk);
    n_vec++; if (q[2] !== 1'b1 || done !== 4'b0010) begin n_err++; $display("FAIL same_first: q2 %b done %b want 1 0010", q[2], done); end
    req[1] = 1'b0;
    @(negedge clk);
    n_vec++; if (gnt !== 4'b0100) begin n_err++; $display("FAIL same_gnt2: got %b want 0100", gnt); end
    @(negedge clk);
    n_vec++; if (q[2] !== 1'b0 || done !== 4'b0100) begin n_err++; $display("FAIL same_second: q2 %b done %b want 0 0100", q[2], done); end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_snapshot();
    do_reset();
    set_cmd(3, 2'b10, 3'd7);
    req = 4'b1000;
    @(negedge clk);
    n_vec++; if (gnt !== 4'b1000) begin n_err++; $display("FAIL snap_gnt: got %b want 1000", gnt); end
    set_cmd(3, 2'b01, 3'd0);
    @(negedge clk);
    n_vec++; if (q !== 8'h80 || done !== 4'b1000) begin n_err++; $display("FAIL snap_apply: q %h done %b want 80 1000", q, done); end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_exec();
    do_reset();
    set_cmd(0, 2'b10, 3'd1);
    req = 4'b0001;
    @(negedge clk);
    @(negedge clk);
    req = '0;
    @(negedge clk);
    n_vec++; if (q !== 8'h02) begin n_err++; $display("FAIL midrst_pre_q: got %h want 02", q); end
    set_cmd(0, 2'b10, 3'd6);
    req = 4'b0001;
    @(negedge clk);
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL midrst_busy: got %b want 1", busy); end
    #2 rst = 1'b1;
    #1;
    n_vec++; if (q !== 8'h00 || qbar !== 8'hFF) begin n_err++; $display("FAIL midrst_async_q: q %h qbar %h want 00 ff", q, qbar); end
    n_vec++; if (gnt !== 4'b0000 || busy !== 1'b0) begin n_err++; $display("FAIL midrst_async_ctl: gnt %b busy %b want 0000 0", gnt, busy); end
    req = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_vec++; if (q !== 8'h00 || done !== 4'b0000 || err !== 1'b0) begin n_err++; $display("FAIL midrst_after: q %h done %b err %b want 00 0000 0", q, done, err); end
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      n_vec++; if (q !== m_q)       begin n_err++; $display("FAIL rnd_q cyc%0d: got %h want %h", cyc, q, m_q); end
      n_vec++; if (qbar !== ~m_q)   begin n_err++; $display("FAIL rnd_qbar cyc%0d: got %h want %h", cyc, qbar, ~m_q); end
      n_vec++; if (gnt !== m_gnt)   begin n_err++; $display("FAIL rnd_gnt cyc%0d: got %b want %b", cyc, gnt, m_gnt); end
      n_vec++; if (done !== m_done) begin n_err++; $display("FAIL rnd_done cyc%0d: got %b want %b", cyc, done, m_done); end
      n_vec++; if (err !== m_err)   begin n_err++; $display("FAIL rnd_err cyc%0d: got %b want %b", cyc, err, m_err); end
      n_vec++; if (busy !== m_exec) begin n_err++; $display("FAIL rnd_busy cyc%0d: got %b want %b", cyc, busy, m_exec); end
      for (int i = 0; i < NREQ; i++) begin
        if (done[i]) begin
          req[i] = 1'b0;
        end else if (!req[i]) begin
          if ($urandom_range(2) == 0) begin
            set_cmd(i, 2'($urandom_range(3)), AW'($urandom_range(NFLAGS-1)));
            req[i] = 1'b1;
          end
        end else if ($urandom_range(4) == 0) begin
          set_cmd(i, 2'($urandom_range(3)), AW'($urandom_range(NFLAGS-1)));
        end
      end
    end
    req = '0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst  = 1'b1;
    req  = '0;
    cmd  = '0;
    addr = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_forbidden();
    test_same_flag();
    test_snapshot();
    test_reset_mid_exec();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
